// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, paces fetch/execute with a memory
// handshake, resolves branches/jumps and keeps a small return-address stack.
module pc_sequencer #(
  parameter int               WIDTH       = 32,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = {WIDTH{1'b0}}
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mem_ready,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             target,
  input  logic [WIDTH-1:0]             cond_value,
  output logic [WIDTH-1:0]             pc,
  output logic [1:0]                   pc_sel,
  output logic                         fetch_req,
  output logic                         ir_load,
  output logic                         halted,
  output logic                         stack_err,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [2:0] OP_BRF  = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_TGT = 2'b01;
  localparam logic [1:0] SEL_RET = 2'b10;

  localparam logic [DW-1:0] DEPTH_FULL  = DW'(STACK_DEPTH);
  localparam logic [DW-1:0] DEPTH_EMPTY = {DW{1'b0}};
  localparam logic [DW-1:0] DEPTH_ONE   = {{(DW-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [WIDTH-1:0] pc_r;
  logic [DW-1:0]    depth_r;
  logic             err_r;
  logic [WIDTH-1:0] stack_r [STACK_DEPTH];

  logic [1:0]       next_state_s;
  logic [WIDTH-1:0] next_pc_s;
  logic [1:0]       sel_s;
  logic             push_s;
  logic             pop_s;
  logic             err_set_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic [AW-1:0]    push_idx_s;
  logic [AW-1:0]    top_idx_s;

  // When full, the low bits of depth wrap to 0 so top_idx lands on the last slot.
  assign pc_inc_s   = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
  assign push_idx_s = depth_r[AW-1:0];
  assign top_idx_s  = depth_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

  // Next-state, next-PC and stack-control decode.
  always_comb begin
    next_state_s = state_r;
    next_pc_s    = pc_r;
    sel_s        = SEL_SEQ;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_FETCH;
        else       next_state_s = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ready) next_state_s = S_EXEC;
        else           next_state_s = S_FETCH;
      end
      S_EXEC: begin
        next_state_s = S_FETCH;
        case (op)
          OP_BRF: begin
            if (cond_value == {WIDTH{1'b0}}) begin
              sel_s     = SEL_TGT;
              next_pc_s = target;
            end else begin
              next_pc_s = pc_inc_s;
            end
          end
          OP_JMP: begin
            sel_s     = SEL_TGT;
            next_pc_s = target;
          end
          OP_CALL: begin
            if (depth_r == DEPTH_FULL) begin
              err_set_s    = 1'b1;
              next_state_s = S_HALTED;
            end else begin
              push_s    = 1'b1;
              sel_s     = SEL_TGT;
              next_pc_s = target;
            end
          end
          OP_RET: begin
            if (depth_r == DEPTH_EMPTY) begin
              err_set_s    = 1'b1;
              next_state_s = S_HALTED;
            end else begin
              pop_s     = 1'b1;
              sel_s     = SEL_RET;
              next_pc_s = stack_r[top_idx_s];
            end
          end
          OP_HALT: next_state_s = S_HALTED;
          default: next_pc_s = pc_inc_s;
        endcase
      end
      S_HALTED: next_state_s = S_HALTED;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Control state, PC, stack occupancy and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      pc_r    <= RESET_PC;
      depth_r <= DEPTH_EMPTY;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      pc_r    <= next_pc_s;
      if (push_s)     depth_r <= depth_r + DEPTH_ONE;
      else if (pop_s) depth_r <= depth_r - DEPTH_ONE;
      if (err_set_s)  err_r <= 1'b1;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push_s && !reset) stack_r[push_idx_s] <= pc_inc_s;
  end

  // Strobes are gated by reset so a reset cycle never looks like a capture.
  assign pc        = pc_r;
  assign pc_sel    = sel_s;
  assign fetch_req = (state_r == S_FETCH) && !reset;
  assign ir_load   = fetch_req && mem_ready;
  assign halted    = (state_r == S_HALTED);
  assign stack_err = err_r;
  assign depth     = depth_r;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the processor datapath: it owns the PC register and drives the 3-way next-PC select (sequential / target / return address) that steers the PC multiplexer. A fetch/execute state machine with a memory handshake paces the fetches. Conditional branches use the zero test of an operand. A small return-address stack provides call/return. It sits between instruction memory, the instruction register and the datapath's next-PC selection.

## Interface
- WIDTH, 32, PC and data width
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next edge
- start  in  1  leaves IDLE; ignored in any other state
- mem_ready  in  1  instruction memory has the word at `pc` this cycle
- op  in  3  decoded opcode from IR, sampled in EXEC: 000 SEQ, 001 BRF, 010 JMP, 011 CALL, 100 RET, 101 HALT, others = SEQ
- target  in  WIDTH  branch/jump/call destination, sampled in EXEC
- cond_value  in  WIDTH  BRF operand; "false" = all zero
- pc  out  WIDTH  current program counter (registered)
- pc_sel  out  2  next-PC select: 00 pc+1, 01 target, 10 stack top; 00 outside EXEC
- fetch_req  out  1  instruction-fetch request, high throughout FETCH
- ir_load  out  1  one-cycle pulse: capture the memory word into the IR
- halted  out  1  core stopped (HALT op or stack error)
- stack_err  out  1  sticky; stack overflow or underflow occurred
- depth  out  clog2(STACK_DEPTH)+1  current stack occupancy

## Operation
- States: IDLE, FETCH, EXEC, HALTED. Reset → IDLE.
- IDLE: all strobes low. `start`=1 → FETCH.
- FETCH: fetch_req=1. When mem_ready=1: ir_load=1 in that same cycle, then → EXEC. When mem_ready=0: stay in FETCH with pc unchanged; no timeout.
- EXEC (one cycle): pc_sel is combinational from op and the stack state. The new PC loads on the exiting edge.
  - SEQ: pc ← pc+1, sel 00.
  - BRF: if cond_value==0, pc ← target (sel 01); else pc ← pc+1 (sel 00).
  - JMP: pc ← target, sel 01.
  - CALL: push pc+1, then pc ← target (sel 01).
    - If depth==STACK_DEPTH: no push, pc unchanged, stack_err←1, → HALTED.
  - RET: pc ← top of stack, pop, sel 10.
    - If depth==0: pc unchanged, sel 00, stack_err←1, → HALTED.
  - HALT: pc unchanged, sel 00, → HALTED.
  - All non-halting cases → FETCH.
- HALTED: halted=1, all strobes low, pc frozen. Exit only by reset; `start` is ignored.
- Arithmetic: pc+1 is modulo 2^WIDTH, so 0xFFFFFFFF+1 = 0 with no flag. Pushed return addresses wrap the same way.
- Stack: LIFO holding return addresses only. The stack is not readable externally except through RET.

## Timing
- Reset values: pc=RESET_PC, pc_sel=00, fetch_req=0, ir_load=0, halted=0, stack_err=0, depth=0, state IDLE, stack contents don't-care.
- Reset asserted in any state, including mid-FETCH with mem_ready high or during EXEC: the reset wins on that edge. No PC update, no push/pop, stack_err cleared.
- Instruction latency: minimum 2 cycles (FETCH with immediate mem_ready, then EXEC); each cycle of mem_ready low adds 1.
- pc is stable from EXEC's exit edge through the whole next FETCH; memory addresses with `pc` directly.
- halted rises on the edge leaving EXEC. pc_sel/fetch_req/ir_load are low from that cycle on.
- op, target and cond_value must be stable during EXEC only; their values in other states are ignored.
- depth updates on the same edge as pc.

## Test plan
- Reset, start, mem_ready always 1, four SEQ ops → pc 0,1,2,3,4, one EXEC every 2 cycles; ir_load pulses once per instruction.
- BRF target=0x40: with cond_value=0 → pc=0x40, pc_sel=01 in EXEC. With cond_value=5 → pc=old+1, pc_sel=00.
- mem_ready held low 3 cycles in FETCH → fetch_req high 4 cycles, pc constant, single ir_load on the ready cycle.
- CALL 0x100 at pc=7, then RET → pc 0x100 then 8, depth 1 then 0. Then STACK_DEPTH+1 CALLs → last one sets stack_err, halted, pc = last target.
- RET on empty stack → stack_err=1, halted=1, pc unchanged. Then start pulses → no change. Then reset → pc=RESET_PC, flags 0.
- pc=0xFFFFFFFF with SEQ → pc=0. Reset asserted during FETCH with mem_ready=1 → no ir_load effect, state IDLE, pc=RESET_PC.
